// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and
// instruction memory.
//   imem_req   : fetch request (driven by the fetch unit)
//   imem_addr  : fetch address (driven by the fetch unit)
//   imem_ack   : response valid, meaningful only while imem_req=1 (memory)
//   imem_rdata : instruction word, qualified by imem_ack (memory)
// The master modport is the fetch side, the slave modport the memory side.
interface fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the program counter, issues fetches over a
// req/ack handshake of arbitrary latency (>= 1 cycle), writes fetched
// instructions into the IF/ID register, parks one instruction in a hold
// buffer while decode stalls, and discards responses made stale by a branch
// redirect.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   pc_next      : next PC from the external PC adder (equals pc under halt,
//                  the branch target under pc_src)
//   pc_src       : branch redirect / pipeline flush
//   halt         : stop issuing new fetches
//   stall        : decode cannot accept, IF/ID must hold
//   pc           : current PC, to the PC adder
//   imem         : instruction-memory bus (master side)
//   if_id_valid, if_id_inst, if_id_pc : IF/ID pipeline register
module fetch_unit #(
  parameter int INST_ADDR_WIDTH = 16,
  parameter int INST_WIDTH      = 16,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INST_ADDR_WIDTH-1:0] pc_next,
  input  logic                       pc_src,
  input  logic                       halt,
  input  logic                       stall,
  output logic [INST_ADDR_WIDTH-1:0] pc,
  fetch_unit_if.master               imem,
  output logic                       if_id_valid,
  output logic [INST_WIDTH-1:0]      if_id_inst,
  output logic [INST_ADDR_WIDTH-1:0] if_id_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                     state;
  state_t                     state_next;
  state_t                     resume;
  logic                       req;
  logic                       pending;
  logic [INST_ADDR_WIDTH-1:0] redir_pc;
  logic [INST_WIDTH-1:0]      hold_inst;
  logic [INST_ADDR_WIDTH-1:0] hold_pc;

  logic                       ack;
  logic                       accept;
  logic                       load_fetch;
  logic                       load_held;
  logic                       capture;
  logic                       pc_load;
  logic [INST_ADDR_WIDTH-1:0] pc_load_val;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  always_comb begin
    // An ack outside REQ (e.g. a late response after reset) is ignored.
    ack         = imem.imem_ack & (state == REQ);
    accept      = ack & ~pending & ~pc_src;
    resume      = halt ? IDLE : REQ;
    state_next  = state;
    pc_load     = 1'b0;
    pc_load_val = pc_next;

    case (state)
      IDLE: begin
        if (!halt)
          state_next = REQ;
        pc_load = pc_src;
      end
      REQ: begin
        if (ack) begin
          state_next = (accept && stall) ? HOLD : resume;
          pc_load    = 1'b1;
          // A redirect recorded earlier takes effect now; a redirect in the
          // very same cycle is newer and wins.
          if (pending && !pc_src)
            pc_load_val = redir_pc;
        end
      end
      HOLD: begin
        if (pc_src || !stall) begin
          state_next = resume;
          pc_load    = pc_src;
        end
      end
      default: state_next = IDLE;
    endcase

    load_fetch = accept & ~stall;
    load_held  = (state == HOLD) & ~pc_src & ~stall;
    capture    = accept & stall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req         <= 1'b0;
      pc          <= RESET_PC;
      pending     <= 1'b0;
      redir_pc    <= '0;
      hold_inst   <= '0;
      hold_pc     <= '0;
      if_id_valid <= 1'b0;
      if_id_inst  <= '0;
      if_id_pc    <= '0;
    end else begin
      state <= state_next;
      req   <= (state_next == REQ);

      if (pc_load)
        pc <= pc_load_val;

      // A redirect while the response is outstanding cannot cancel it; the
      // target is remembered and the response is dropped when it arrives.
      if (state == REQ) begin
        if (ack) begin
          pending <= 1'b0;
        end else if (pc_src) begin
          pending  <= 1'b1;
          redir_pc <= pc_next;
        end
      end

      if (capture) begin
        hold_inst <= imem.imem_rdata;
        hold_pc   <= pc;
      end

      // Flush beats stall beats load; otherwise an empty cycle is a bubble.
      if (pc_src) begin
        if_id_valid <= 1'b0;
      end else if (!stall) begin
        if (load_fetch) begin
          if_id_valid <= 1'b1;
          if_id_inst  <= imem.imem_rdata;
          if_id_pc    <= pc;
        end else if (load_held) begin
          if_id_valid <= 1'b1;
          if_id_inst  <= hold_inst;
          if_id_pc    <= hold_pc;
        end else begin
          if_id_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the program-counter register, drives `pc` to the PC adder, and loads the adder's `pc_next` result.
- Issues requests to instruction memory over a req/ack handshake with variable latency of at least 1 cycle.
- Writes each fetched instruction into the IF/ID pipeline register.
- Handles decode stalls through a one-entry hold buffer, and branch redirects through flush/discard logic.

Parameters:
- INST_ADDR_WIDTH, 16, width of PC and instruction addresses.
- INST_WIDTH, 16, width of an instruction word.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_next  in  INST_ADDR_WIDTH  next PC from the PC adder. Under halt it equals pc; under pc_src it equals the branch target.
- pc_src  in  1  branch-taken redirect; also the pipeline flush.
- halt  in  1  stop issuing new fetches.
- stall  in  1  decode cannot accept; IF/ID must hold.
- pc  out  INST_ADDR_WIDTH  current PC; goes to the PC adder pc_in.
- imem_req  out  1  fetch request.
- imem_addr  out  INST_ADDR_WIDTH  fetch address; equals pc.
- imem_ack  in  1  response valid; only meaningful while imem_req=1.
- imem_rdata  in  INST_WIDTH  instruction data; qualified by imem_ack.
- if_id_valid  out  1  IF/ID holds a valid instruction.
- if_id_inst  out  INST_WIDTH  IF/ID instruction.
- if_id_pc  out  INST_ADDR_WIDTH  address of the IF/ID instruction.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, state=IDLE, imem_req=0.
  - if_id_valid=0, if_id_inst=0, if_id_pc=0.
  - Hold buffer empty; redirect-pending flag=0; redir_pc=0.
  - Reset asserted mid-request abandons the request; a late imem_ack arriving while req=0 is ignored.
- States: IDLE, REQ, HOLD. imem_req=1 only in REQ (Moore). imem_addr=pc at all times.
- IDLE:
  - !halt -> REQ next cycle.
  - pc_src=1 -> pc<=pc_next.
- REQ: request stays asserted and pc stays stable until imem_ack. A cycle is an "accept" when imem_ack=1, no redirect is pending, and pc_src=0.
  - Accept with stall=0: IF/ID <= {1, imem_rdata, pc}; pc<=pc_next; stay in REQ, or go to IDLE if halt=1.
  - Accept with stall=1: hold buffer <= {imem_rdata, pc}; pc<=pc_next; go to HOLD. IF/ID unchanged.
  - pc_src=1 and imem_ack=0: set pending=1 and redir_pc<=pc_next. Request continues; the outstanding response is not abandoned.
  - imem_ack=1 with pending=1: discard data; pc<=redir_pc; clear pending; go to REQ, or IDLE if halt=1.
  - imem_ack=1 with pc_src=1 in the same cycle: discard data; pc<=pc_next; go to REQ, or IDLE if halt=1.
  - halt rising without ack: keep requesting until ack, then go to IDLE.
- HOLD: imem_req=0.
  - stall falls: IF/ID <= {1, held}; buffer empty; go to REQ, or IDLE if halt=1.
  - pc_src=1: drop the held entry; pc<=pc_next; go to REQ, or IDLE if halt=1.
- IF/ID rules, per cycle:
  - pc_src=1 forces if_id_valid<=0. This has priority over stall and any load.
  - Otherwise stall=1 holds all IF/ID fields.
  - Otherwise, if nothing loads this cycle, if_id_valid<=0 (bubble); inst and pc fields keep their old values.
- Throughput: one instruction per cycle when imem_ack arrives in the cycle after req rises and stall=0. Lower rates follow memory latency.
- Arithmetic: pc is stored as given with no internal increment; wrap-around is handled by the PC adder (0xFFFE+2 -> 0x0000 is accepted as-is).

Test Plan:
- Reset then release, halt=0, zero-wait memory (ack every REQ cycle), adder pc_next=pc+2 -> imem_addr 0x0000, 0x0002, 0x0004 on successive cycles; if_id_pc lags by 1 cycle; if_id_valid=1 continuously.
- 3-cycle memory latency -> imem_req held 3 cycles with imem_addr constant; one IF/ID load per ack; if_id_valid=0 between loads.
- stall=1 for 4 cycles arriving as ack returns inst 0xA5A5 at 0x0010 -> IF/ID unchanged; state HOLD; imem_req=0. When stall falls: if_id_inst=0xA5A5, if_id_pc=0x0010; next fetch at 0x0012.
- pc_src=1 with pc_next=0x0100 while a fetch of 0x0020 is pending, ack 2 cycles later -> data discarded; if_id_valid=0; next imem_addr=0x0100.
- pc_src coincident with imem_ack (target 0x0040) -> response dropped; IF/ID invalidated; next request to 0x0040.
- halt=1 mid-request -> request completes on ack, then state IDLE with imem_req=0 and pc stable. halt=0 -> fetching resumes at the held pc.
